// File: rtl/zap_thumb_fetch_queue.sv
// Fetch-to-decode queue: unpacks 32-bit fetch words into ARM or Thumb-halfword entries.
// Optional same-cycle bypass of an empty queue is enabled with `define ZAP_TFQ_BYPASS_EN.
module zap_thumb_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_stall,
  input  logic [31:0]      i_instruction,
  input  logic             i_instruction_valid,
  input  logic [31:0]      i_pc,
  input  logic             i_iabort,
  input  logic [1:0]       i_taken,
  input  logic             i_cpsr_t,
  output logic             o_ready,
  output logic [31:0]      o_instruction,
  output logic             o_valid,
  output logic [31:0]      o_pc,
  output logic             o_iabort,
  output logic [1:0]       o_taken,
  output logic             o_compressed,
  output logic [PTR_W:0]   o_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        iabort;
    logic [1:0]  taken;
    logic        compressed;
  } tfq_entry_t;

  tfq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_ptr_p1;
  logic [PTR_W:0]   count_q;
  tfq_entry_t       e0, e1, head;
  logic [1:0]       n_enq;
  logic             n_deq, accept;

  // Registered count only: a same-cycle dequeue never opens a slot.
  assign o_ready   = (count_q <= (PTR_W+1)'(DEPTH-2));
  assign accept    = i_instruction_valid & o_ready & ~i_clear;
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign o_count   = count_q;

  always_comb begin
    e0    = '0;
    e1    = '0;
    n_enq = 2'd0;
    if (accept) begin
      if (i_iabort) begin
        e0    = '{instr: 32'h0, pc: i_pc, iabort: 1'b1, taken: i_taken, compressed: i_cpsr_t};
        n_enq = 2'd1;
      end else if (!i_cpsr_t) begin
        e0    = '{instr: i_instruction, pc: {i_pc[31:2], 2'b00}, iabort: 1'b0,
                  taken: i_taken, compressed: 1'b0};
        n_enq = 2'd1;
      end else if (!i_pc[1]) begin
        e0    = '{instr: {16'h0, i_instruction[15:0]}, pc: i_pc, iabort: 1'b0,
                  taken: i_taken, compressed: 1'b1};
        e1    = '{instr: {16'h0, i_instruction[31:16]}, pc: i_pc + 32'd2, iabort: 1'b0,
                  taken: i_taken, compressed: 1'b1};
        n_enq = 2'd2;
      end else begin
        // Branch into the upper halfword: the lower one is not part of the stream.
        e0    = '{instr: {16'h0, i_instruction[31:16]}, pc: i_pc, iabort: 1'b0,
                  taken: i_taken, compressed: 1'b1};
        n_enq = 2'd1;
      end
    end
    n_deq   = (count_q != '0) & ~i_stall & ~i_clear;
    head    = mem[rd_ptr];
    o_valid = (count_q != '0);
`ifdef ZAP_TFQ_BYPASS_EN
    if (count_q == '0 && accept && !i_iabort) begin
      head    = e0;
      o_valid = 1'b1;
      // Bypassed entry consumed this cycle; only the remainder is stored.
      if (!i_stall) begin
        e0    = e1;
        n_enq = n_enq - 2'd1;
      end
    end
`endif
  end

  assign o_instruction = head.instr;
  assign o_pc          = head.pc;
  assign o_iabort      = head.iabort;
  assign o_taken       = head.taken;
  assign o_compressed  = head.compressed;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (n_enq != 2'd0) mem[wr_ptr]    <= e0;
      if (n_enq == 2'd2) mem[wr_ptr_p1] <= e1;
      wr_ptr  <= wr_ptr + PTR_W'(n_enq);
      rd_ptr  <= rd_ptr + PTR_W'(n_deq);
      count_q <= count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
    end
  end

endmodule

// File: tb/tb_zap_thumb_fetch_queue.sv
// Scoreboard bench for zap_thumb_fetch_queue: directed scenarios then random traffic.
module tb_zap_thumb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic i_clk = 1'b0, i_reset = 1'b1, i_clear = 1'b0, i_stall = 1'b0;
  logic [31:0] i_instruction = '0, i_pc = '0;
  logic i_instruction_valid = 1'b0, i_iabort = 1'b0, i_cpsr_t = 1'b0;
  logic [1:0] i_taken = '0;
  logic o_ready, o_valid, o_iabort, o_compressed;
  logic [31:0] o_instruction, o_pc;
  logic [1:0] o_taken;
  logic [PTR_W:0] o_count;

  zap_thumb_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_stall(i_stall),
    .i_instruction(i_instruction), .i_instruction_valid(i_instruction_valid),
    .i_pc(i_pc), .i_iabort(i_iabort), .i_taken(i_taken), .i_cpsr_t(i_cpsr_t),
    .o_ready(o_ready), .o_instruction(o_instruction), .o_valid(o_valid),
    .o_pc(o_pc), .o_iabort(o_iabort), .o_taken(o_taken),
    .o_compressed(o_compressed), .o_count(o_count));

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        iabort;
    logic [1:0]  taken;
    logic        comp;
  } exp_t;

  exp_t sb[$];    // entries held by the queue after the last edge
  exp_t pend[$];  // entries accepted at the coming edge
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs vs. the model's queue, then retire the head if it leaves.
  always @(negedge i_clk) begin
    if (i_reset) begin
      sb.delete();
    end else begin
      check("valid", 68'(o_valid), 68'(sb.size() != 0));
      check("count", 68'(o_count), 68'(sb.size()));
      check("ready", 68'(o_ready), 68'(sb.size() <= DEPTH-2));
      if (sb.size() != 0)
        check("head", {o_instruction, o_pc, o_iabort, o_taken, o_compressed}, 68'(sb[0]));
      if (i_clear) sb.delete();
      else if (sb.size() != 0 && !i_stall) void'(sb.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic t, input logic ab, input logic [1:0] tk,
                       input logic st, input logic cl);
    exp_t e;
    @(posedge i_clk);
    while (pend.size() > 0) sb.push_back(pend.pop_front());
    #1;
    i_instruction_valid = v; i_instruction = w; i_pc = pc; i_cpsr_t = t;
    i_iabort = ab; i_taken = tk; i_stall = st; i_clear = cl;
    if (v && !cl && sb.size() <= DEPTH-2) begin
      if (ab) begin
        e = '{instr: 32'h0, pc: pc, iabort: 1'b1, taken: tk, comp: t};
        pend.push_back(e);
      end else if (!t) begin
        e = '{instr: w, pc: pc & 32'hFFFF_FFFC, iabort: 1'b0, taken: tk, comp: 1'b0};
        pend.push_back(e);
      end else begin
        if ((pc % 4) == 0) begin
          e = '{instr: w % 65536, pc: pc, iabort: 1'b0, taken: tk, comp: 1'b1};
          pend.push_back(e);
          e = '{instr: w / 65536, pc: pc + 2, iabort: 1'b0, taken: tk, comp: 1'b1};
        end else begin
          e = '{instr: w / 65536, pc: pc, iabort: 1'b0, taken: tk, comp: 1'b1};
        end
        pend.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 68'(o_valid), 68'(0));
    check("rst_count", 68'(o_count), 68'(0));
    check("rst_ready", 68'(o_ready), 68'(1));
    check("rst_head", {o_instruction, o_pc, o_iabort, o_taken, o_compressed}, 68'(0));
  endtask

  initial begin
    logic [31:0] w, pc;
    #12;
    check_reset_outputs();
    @(posedge i_clk); #1 i_reset = 1'b0;

    // ARM single word
    drive(1'b1, 32'hE3A00001, 32'h100, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    idle(2);
    // Thumb aligned word: two halfwords
    drive(1'b1, 32'h46C02001, 32'h200, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    idle(3);
    // Thumb odd halfword entry
    drive(1'b1, 32'h46C02001, 32'h202, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(2);
    // Fill under stall; third word must be refused
    drive(1'b1, 32'h11112222, 32'h300, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h33334444, 32'h304, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h55556666, 32'h308, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h55556666, 32'h308, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(6);
    // Abort marker in Thumb state
    drive(1'b1, 32'hDEADBEEF, 32'h400, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    idle(2);
    // Flush at count=3 with a word presented, then normal traffic
    drive(1'b1, 32'hAAAABBBB, 32'h500, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 32'hE1A00000, 32'h504, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    drive(1'b1, 32'hE1A00001, 32'h508, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
    drive(1'b1, 32'hE1A00002, 32'h600, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    idle(3);

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 800; i++) begin
      if (i == 400) begin
        @(posedge i_clk);
        pend.delete();
        #1 i_reset = 1'b1;
        i_instruction_valid = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
      end
      w  = $urandom;
      pc = $urandom;
      pc[0] = 1'b0;
      drive(($urandom % 4) != 0, w, pc, 1'($urandom % 2), ($urandom % 16) == 0,
            2'($urandom % 4), ($urandom % 3) == 0, ($urandom % 40) == 0);
    end
    idle(8);
    @(negedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/zap_thumb_fetch_queue.md
# zap_thumb_fetch_queue

Parametrised fetch-to-decode instruction queue that unpacks 32-bit fetch words into per-instruction entries. In ARM state each word becomes one entry; in Thumb state each word becomes up to two halfword entries with their own PCs. It sits between the fetch stage and the 16-to-32-bit decompressor. It replaces the single pipeline register that expects memory to deliver one instruction per word, and decouples fetch from decode stalls.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_clear  in  1  synchronous flush (ORed writeback/ALU/decode clears).
- i_stall  in  1  downstream stall; the head entry is held.
- i_instruction  in  32  fetched word.
- i_instruction_valid  in  1  word valid.
- i_pc  in  32  byte address of the word (pc[0]=0).
- i_iabort  in  1  instruction abort for this fetch.
- i_taken  in  2  predictor state for this fetch.
- i_cpsr_t  in  1  Thumb state.
- o_ready  out  1  queue can accept a word this cycle.
- o_instruction  out  32  head entry; Thumb entries are zero-extended halfwords.
- o_valid  out  1  head entry valid.
- o_pc  out  32  head entry address.
- o_iabort  out  1  head entry is an abort marker.
- o_taken  out  2  head entry predictor state.
- o_compressed  out  1  head entry is a Thumb halfword.
- o_count  out  PTR_W+1  occupied entries.

## Operation
- Storage: DEPTH entries of {instr[31:0], pc[31:0], iabort, taken[1:0], compressed}, plus read/write pointers (PTR_W bits, wrap modulo DEPTH) and a count (PTR_W+1 bits).
- Accept: a word is accepted when i_instruction_valid & o_ready & !i_clear.
- o_ready = (count <= DEPTH-2). It uses the registered count and ignores any same-cycle dequeue, so it is conservative.

Enqueue count per accepted word, n_enq:
- i_iabort=1: 1 entry, instr=0, pc=i_pc, iabort=1, compressed=i_cpsr_t. Applies in either state.
- ARM (i_cpsr_t=0): 1 entry, instr=i_instruction, pc={i_pc[31:2],2'b00}, compressed=0.
- Thumb with i_pc[1]=0: 2 entries. First {16'h0, i_instruction[15:0]} at pc=i_pc. Then {16'h0, i_instruction[31:16]} at pc=i_pc+2.
- Thumb with i_pc[1]=1 (branch to an odd halfword): 1 entry, {16'h0, i_instruction[31:16]} at pc=i_pc.
- i_taken is copied to every entry from the word.

Dequeue and flush:
- Dequeue: n_deq = (count!=0) & !i_stall & !i_clear. The read pointer advances by 1.
- Next state: count_next = count + n_enq - n_deq. Enqueue and dequeue in the same cycle are both performed. The write pointer advances by n_enq, modulo DEPTH.
- i_clear: pointers and count go to 0 next edge. Any same-cycle input word is dropped and no dequeue happens. i_clear has priority over everything.
- Head outputs: o_valid = (count!=0). The o_instruction/o_pc/o_iabort/o_taken/o_compressed outputs are driven from the entry at the read pointer. Contents of empty entries are don't-care, but entries are reset to 0.

## Timing
- Reset (asynchronous assert, clocked deassert): pointers=0, count=0, all entries=0.
- Output values during reset: o_valid=0, o_count=0, o_ready=1, o_instruction=0, o_pc=0, o_iabort=0, o_taken=0, o_compressed=0.
- Reset mid-operation discards all entries immediately.
- Latency: a word accepted at edge N has its first entry on the outputs after edge N (cycle N+1) if the queue was empty. The second Thumb halfword follows in cycle N+2 when there is no stall.
- Throughput: 1 entry out per cycle; up to 2 entries in per cycle.
- Full: with count=DEPTH-1 or DEPTH, o_ready=0. A presented word is not accepted, and fetch must hold or refetch it.
- Empty: o_valid=0. i_stall has no effect on state.
- i_cpsr_t is sampled per accepted word. Existing entries keep their compressed flag.

## Configuration
- ZAP_TFQ_BYPASS_EN defined: when count=0, an accepted non-abort word is presented combinationally on the outputs in the same cycle.
  - In ARM state, or Thumb with pc[1]=1, the word is not written if it is dequeued the same cycle (!i_stall).
  - In Thumb with pc[1]=0, the low halfword bypasses and only the high halfword is written.
  - o_valid = (count!=0) | (accept & !i_iabort).
- Not defined: no bypass; 1-cycle minimum latency as above.

## Test plan
- ARM, DEPTH=4: word 0xE3A00001 at pc 0x100, no stall -> cycle N+1: o_valid=1, o_instruction=0xE3A00001, o_pc=0x100, o_compressed=0. Cycle N+2: o_valid=0.
- Thumb: word 0x46C02001 at pc 0x200 -> outputs 0x00002001/pc 0x200, then 0x000046C0/pc 0x202, both with o_compressed=1.
- Thumb odd entry: word 0x46C02001 at pc 0x202 -> single entry 0x000046C0/pc 0x202; o_count peaks at 1.
- Full: i_stall=1, Thumb words at pc 0x300 and 0x304 -> o_count=2 with o_ready=1, then o_count=4 with o_ready=0. A third word is not accepted. Releasing the stall drains 0x300, 0x302, 0x304, 0x306 in order.
- Abort: i_iabort=1, i_cpsr_t=1, pc 0x400 -> one entry with o_iabort=1, o_instruction=0, o_pc=0x400.
- Flush: count=3 with i_clear=1 and a valid word presented -> next cycle o_valid=0, o_count=0, o_ready=1. A word presented the following cycle emerges normally.
